// File: rtl/snow64_vector_alu_sequencer_pkg.sv
// Shared types and constants for the snow64 vector ALU sequencer.
//   oper_t       - opcode encoding (10..15 reserved, result is zero)
//   type_size_t  - element width select: 8/16/32/64 bits
//   state_t      - sequencer FSM states
//   ELEM_COUNT   - elements per 256-bit line, indexed by type size
//   elem_mask / elem_extend - element isolation and 64-bit extension
package snow64_vector_alu_pkg;

    localparam int DEFAULT_WIDTH__LINE   = 256;
    localparam int DEFAULT_WIDTH__SCALAR = 64;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLTU = 4'd2,
        OP_SLTS = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SAR  = 4'd9
    } oper_t;

    typedef enum logic [1:0] {
        TS_8  = 2'd0,
        TS_16 = 2'd1,
        TS_32 = 2'd2,
        TS_64 = 2'd3
    } type_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Element [ts] holds N for that type size: 32, 16, 8, 4.
    localparam logic [3:0][5:0] ELEM_COUNT = {6'd4, 6'd8, 6'd16, 6'd32};

    function automatic logic [63:0] elem_mask(input logic [1:0] ts);
        case (ts)
            TS_8:    elem_mask = 64'h0000_0000_0000_00FF;
            TS_16:   elem_mask = 64'h0000_0000_0000_FFFF;
            TS_32:   elem_mask = 64'h0000_0000_FFFF_FFFF;
            default: elem_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Keep the low W bits of v; when sgn is set, replicate bit W-1 upward.
    function automatic logic [63:0] elem_extend(input logic [63:0] v,
                                                input logic [1:0]  ts,
                                                input logic        sgn);
        logic [63:0] m;
        logic        sbit;
        m = elem_mask(ts);
        case (ts)
            TS_8:    sbit = v[7];
            TS_16:   sbit = v[15];
            TS_32:   sbit = v[31];
            default: sbit = v[63];
        endcase
        elem_extend = (v & m) | ((sgn && sbit) ? ~m : 64'd0);
    endfunction

endpackage

// File: rtl/snow64_vector_alu_sequencer_if.sv
// Request/response bundle between operand fetch and the vector ALU stage.
//   in_start/in_oper/in_type_size/in_a/in_b - request, driven by master
//   out_busy/out_valid/out_data              - status and result line, driven by slave
interface snow64_vector_alu_sequencer_if
    #(parameter int WIDTH__LINE = snow64_vector_alu_pkg::DEFAULT_WIDTH__LINE);

    logic                   in_start;
    logic [3:0]             in_oper;
    logic [1:0]             in_type_size;
    logic [WIDTH__LINE-1:0] in_a;
    logic [WIDTH__LINE-1:0] in_b;
    logic                   out_busy;
    logic                   out_valid;
    logic [WIDTH__LINE-1:0] out_data;

    modport master (
        output in_start, in_oper, in_type_size, in_a, in_b,
        input  out_busy, out_valid, out_data
    );

    modport slave (
        input  in_start, in_oper, in_type_size, in_a, in_b,
        output out_busy, out_valid, out_data
    );

endinterface

// File: rtl/snow64_vector_alu_sequencer_scalar_alu.sv
// Combinational 64-bit scalar ALU used one element per cycle by the sequencer.
//   a, b   - already-extended element operands
//   oper   - opcode (reserved codes yield zero)
//   result - full-width result; the caller truncates to the element width
// Shift amounts are the whole b value; amounts >= WIDTH saturate.

module SetLessThanUnsigned #(parameter int WIDTH = 64) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out
);
    assign out = (a < b);
endmodule

module SetLessThanSigned #(parameter int WIDTH = 64) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out
);
    assign out = ($signed(a) < $signed(b));
endmodule

module ArithmeticShiftRight #(parameter int WIDTH = 64) (
    input  logic [WIDTH-1:0] to_shift,
    input  logic [WIDTH-1:0] amount,
    output logic [WIDTH-1:0] result
);
    localparam int             SHW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(WIDTH);

    always_comb begin
        if (amount >= LIMIT) result = {WIDTH{to_shift[WIDTH-1]}};
        else                 result = $unsigned($signed(to_shift) >>> amount[SHW-1:0]);
    end
endmodule

module snow64_scalar_alu
    import snow64_vector_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH__SCALAR
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    output logic [WIDTH-1:0] result
);
    localparam int               SHW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(WIDTH);

    logic             lt_u, lt_s, shift_sat;
    logic [WIDTH-1:0] sar_res;

    SetLessThanUnsigned  #(.WIDTH(WIDTH)) u_sltu (.a(a), .b(b), .out(lt_u));
    SetLessThanSigned    #(.WIDTH(WIDTH)) u_slts (.a(a), .b(b), .out(lt_s));
    ArithmeticShiftRight #(.WIDTH(WIDTH)) u_sar  (.to_shift(a), .amount(b), .result(sar_res));

    assign shift_sat = (b >= LIMIT);

    always_comb begin
        result = '0;
        case (oper)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLTS: result = {{(WIDTH-1){1'b0}}, lt_s};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = shift_sat ? '0 : (a << b[SHW-1:0]);
            OP_SHR:  result = shift_sat ? '0 : (a >> b[SHW-1:0]);
            OP_SAR:  result = sar_res;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/snow64_vector_alu_sequencer.sv
// Multi-cycle vector ALU stage: latches two 256-bit lines, walks the elements
// one per cycle through snow64_scalar_alu, then pulses out_valid for one cycle.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - slave side of snow64_vector_alu_sequencer_if
// Latency is N+1 cycles from accept to out_valid; next accept N+2 cycles later.
module snow64_vector_alu_sequencer
    import snow64_vector_alu_pkg::*;
#(
    parameter int WIDTH__LINE   = DEFAULT_WIDTH__LINE,
    parameter int WIDTH__SCALAR = DEFAULT_WIDTH__SCALAR
) (
    input  logic                          clk,
    input  logic                          rst_n,
    snow64_vector_alu_sequencer_if.slave  bus
);

    state_t                   state, state_nxt;
    logic [4:0]               cnt;
    logic [3:0]               oper_r;
    logic [1:0]               ts_r;
    logic [WIDTH__LINE-1:0]   a_r, b_r, res_r;

    logic [7:0]               base;
    logic                     last_elem;
    logic                     sgn_a, sgn_b;
    logic [WIDTH__SCALAR-1:0] a_raw, b_raw, a_ext, b_ext, alu_res;

    // Bit offset of the current element within the line.
    always_comb begin
        case (ts_r)
            TS_8:    base = {cnt,      3'b0};
            TS_16:   base = {cnt[3:0], 4'b0};
            TS_32:   base = {cnt[2:0], 5'b0};
            default: base = {cnt[1:0], 6'b0};
        endcase
    end

    assign last_elem = ({1'b0, cnt} == (ELEM_COUNT[ts_r] - 6'd1));

    // Only slts sign-extends B; shift amounts are always unsigned.
    assign sgn_a = (oper_r == OP_SLTS) || (oper_r == OP_SAR);
    assign sgn_b = (oper_r == OP_SLTS);

    assign a_raw = WIDTH__SCALAR'(a_r >> base);
    assign b_raw = WIDTH__SCALAR'(b_r >> base);
    assign a_ext = elem_extend(a_raw, ts_r, sgn_a);
    assign b_ext = elem_extend(b_raw, ts_r, sgn_b);

    snow64_scalar_alu #(.WIDTH(WIDTH__SCALAR)) u_alu (
        .a      (a_ext),
        .b      (b_ext),
        .oper   (oper_r),
        .result (alu_res)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_start) state_nxt = ST_RUN;
            ST_RUN:  if (last_elem)    state_nxt = ST_DONE;
            ST_DONE:                   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.out_busy  = (state != ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.out_data  = res_r;
    end

    // Operand latch, element counter and result-line writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            oper_r <= '0;
            ts_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_start) begin
                        a_r    <= bus.in_a;
                        b_r    <= bus.in_b;
                        oper_r <= bus.in_oper;
                        ts_r   <= bus.in_type_size;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    case (ts_r)
                        TS_8:    res_r[base +: 8]  <= alu_res[7:0];
                        TS_16:   res_r[base +: 16] <= alu_res[15:0];
                        TS_32:   res_r[base +: 32] <= alu_res[31:0];
                        default: res_r[base +: 64] <= alu_res[63:0];
                    endcase
                    if (!last_elem) cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snow64_vector_alu_sequencer.sv
module tb_snow64_vector_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snow64_vector_alu_sequencer_if bus();

    snow64_vector_alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string          name;
        logic [3:0]     op;
        logic [1:0]     ts;
        logic [255:0]   a;
        logic [255:0]   b;
        logic [255:0]   exp;
    } vec_t;

    typedef struct {
        string        name;
        logic [255:0] exp;
        int           t0;
        int           n;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_valid = 0;
    int   n_push = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Keep only the low 7 bits of every element, so shift amounts straddle W.
    function automatic logic [255:0] small_amounts(input logic [255:0] b, input logic [1:0] ts);
        int w;
        logic [255:0] r;
        w = 8 << ts;
        r = '0;
        for (int i = 0; i < 256 / w; i++) r = r | (((b >> (i*w)) & 256'h7F) << (i*w));
        return r;
    endfunction

    function automatic logic [255:0] model(input logic [3:0] op, input logic [1:0] ts,
                                           input logic [255:0] a, input logic [255:0] b);
        int w;
        logic [63:0] m, top, ea, eb, x;
        logic signed [63:0] sa, sbv;
        logic [255:0] r;
        w   = 8 << ts;
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        top = 64'd1 << (w - 1);
        r   = '0;
        for (int i = 0; i < 256 / w; i++) begin
            ea  = 64'(a >> (i*w)) & m;
            eb  = 64'(b >> (i*w)) & m;
            sa  = ((ea & top) != 0) ? (ea | ~m) : ea;
            sbv = ((eb & top) != 0) ? (eb | ~m) : eb;
            case (op)
                4'd0: x = ea + eb;
                4'd1: x = ea - eb;
                4'd2: x = (ea < eb) ? 64'd1 : 64'd0;
                4'd3: x = (sa < sbv) ? 64'd1 : 64'd0;
                4'd4: x = ea & eb;
                4'd5: x = ea | eb;
                4'd6: x = ea ^ eb;
                4'd7: x = (eb >= 64'(w)) ? 64'd0 : (ea << eb);
                4'd8: x = (eb >= 64'(w)) ? 64'd0 : (ea >> eb);
                4'd9: x = (eb >= 64'(w)) ? ((sa < 0) ? m : 64'd0) : 64'(sa >>> eb);
                default: x = 64'd0;
            endcase
            r = r | (256'(x & m) << (i*w));
        end
        return r;
    endfunction

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [1:0] ts,
                                input logic [255:0] a, input logic [255:0] b, input logic [255:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.ts = ts; v.a = a; v.b = b; v.exp = exp;
        return v;
    endfunction

    // Wait for IDLE, present the request for one edge, then scramble the inputs.
    task automatic issue(input vec_t v, input bit push, output int t0);
        int g;
        g = 0;
        @(negedge clk);
        while (bus.out_busy && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) chk({v.name, "_idle_timeout"}, 256'(bus.out_busy), 256'd0);
        bus.in_oper      = v.op;
        bus.in_type_size = v.ts;
        bus.in_a         = v.a;
        bus.in_b         = v.b;
        bus.in_start     = 1'b1;
        t0 = cyc;
        if (push) begin
            sb.push_back('{name: v.name, exp: v.exp, t0: cyc, n: 32 >> v.ts});
            n_push++;
        end
        @(negedge clk);
        bus.in_start = 1'b0;
        bus.in_a     = rand256();
        bus.in_b     = rand256();
        bus.in_oper  = 4'($urandom_range(0, 15));
    endtask

    // Scoreboard: every out_valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 256'd1, 256'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk({e.name, "_data"}, bus.out_data, e.exp);
                chk({e.name, "_latency"}, 256'(cyc - e.t0), 256'(e.n + 1));
            end
        end
    end

    initial begin
        int t0, t1, g, vbefore;
        logic [255:0] a, b;
        vec_t v;

        bus.in_start = 1'b0;
        bus.in_oper = '0; bus.in_type_size = '0; bus.in_a = '0; bus.in_b = '0;

        // Directed vectors with hand-computed results.
        vecs.push_back(mk("add8_ff_02", 4'd0, 2'd0, {32{8'hFF}}, {32{8'h02}}, {32{8'h01}}));
        vecs.push_back(mk("slts16", 4'd3, 2'd1, 256'h8000, 256'h0001, 256'h0001));
        vecs.push_back(mk("sltu16", 4'd2, 2'd1, 256'h8000, 256'h0001, 256'h0000));
        vecs.push_back(mk("sar32_4", 4'd9, 2'd2, 256'h8000_0000, 256'd4, 256'hF800_0000));
        vecs.push_back(mk("sar32_40", 4'd9, 2'd2, 256'h8000_0000, 256'd40, 256'hFFFF_FFFF));
        vecs.push_back(mk("shr32_40", 4'd8, 2'd2, 256'h8000_0000, 256'd40, 256'h0));
        vecs.push_back(mk("shl64_63", 4'd7, 2'd3, 256'd1, 256'd63, 256'h8000_0000_0000_0000));
        vecs.push_back(mk("sub16_wrap", 4'd1, 2'd1, 256'd0, {16{16'h0001}}, {16{16'hFFFF}}));
        vecs.push_back(mk("add64_wrap", 4'd0, 2'd3, {4{64'hFFFF_FFFF_FFFF_FFFF}}, {4{64'd1}}, 256'd0));
        vecs.push_back(mk("rsv12_32", 4'd12, 2'd2, rand256(), rand256(), 256'd0));
        vecs.push_back(mk("rsv15_8", 4'd15, 2'd0, rand256(), rand256(), 256'd0));
        // Random vectors checked against the element-wise model.
        for (int k = 0; k < 12; k++) begin
            logic [3:0] op;
            logic [1:0] ts;
            op = 4'(k % 10);
            ts = 2'(k % 4);
            a = rand256();
            b = rand256();
            if (op >= 4'd7) b = small_amounts(b, ts);
            vecs.push_back(mk($sformatf("rand%0d_op%0d_ts%0d", k, op, ts), op, ts, a, b, model(op, ts, a, b)));
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(bus.out_busy), 256'd0);
        chk("rst_valid", 256'(bus.out_valid), 256'd0);
        chk("rst_data", bus.out_data, 256'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i], 1'b1, t0);

        // Back-to-back issue on W=32: accepts N+2 = 10 cycles apart.
        issue(mk("b2b_a", 4'd12, 2'd2, rand256(), rand256(), 256'd0), 1'b1, t0);
        a = rand256(); b = rand256();
        issue(mk("b2b_b", 4'd6, 2'd2, a, b, a ^ b), 1'b1, t1);
        chk("b2b_spacing", 256'(t1 - t0), 256'd10);

        // Starts held high through RUN and DONE must be ignored.
        issue(mk("shl64_ign", 4'd7, 2'd3, 256'd1, 256'd63, 256'h8000_0000_0000_0000), 1'b1, t0);
        g = 0;
        while (bus.out_busy && g < 50) begin
            bus.in_start     = 1'b1;
            bus.in_oper      = 4'd0;
            bus.in_type_size = 2'd0;
            bus.in_a         = rand256();
            bus.in_b         = rand256();
            @(negedge clk);
            g++;
        end
        bus.in_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ign_idle_busy", 256'(bus.out_busy), 256'd0);
        chk("ign_no_pending", 256'(sb.size()), 256'd0);
        issue(mk("shl64_fresh", 4'd7, 2'd3, {64'd5, 64'd0, 64'd7, 64'd3}, {64'd64, 64'd1, 64'd2, 64'd1},
                 {64'd0, 64'd0, 64'd28, 64'd6}), 1'b1, t0);

        // Reset mid-operation aborts without a valid pulse.
        issue(mk("rst_abort", 4'd0, 2'd0, {32{8'hFF}}, {32{8'h02}}, 256'd0), 1'b0, t0);
        vbefore = n_valid;
        while (cyc < t0 + 10) @(negedge clk);
        chk("abort_busy_before", 256'(bus.out_busy), 256'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 256'(bus.out_busy), 256'd0);
        chk("abort_valid", 256'(bus.out_valid), 256'd0);
        chk("abort_data", bus.out_data, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_valid", 256'(n_valid - vbefore), 256'd0);
        chk("abort_idle", 256'(bus.out_busy), 256'd0);

        // Start together with reset is dropped.
        bus.in_oper = 4'd0; bus.in_type_size = 2'd3;
        bus.in_a = rand256(); bus.in_b = rand256();
        bus.in_start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 256'(bus.out_busy), 256'd0);
        repeat (10) @(negedge clk);
        chk("rst_start_data", bus.out_data, 256'd0);

        // Drain and close out.
        g = 0;
        while ((sb.size() != 0 || bus.out_busy) && g < 200) begin @(negedge clk); g++; end
        chk("drain_pending", 256'(sb.size()), 256'd0);
        chk("valid_count", 256'(n_valid), 256'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: cycle %0d reached, limit exceeded", cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "timeout");
    end

endmodule
